key_load_ctrl: RTL and testbench

- Serial key-programming controller for the wire-obfuscated c17 netlist.
- Accepts a framed serial key stream and checks parity in a shadow register, then atomically commits the key word whose bit pairs drive the mux selects D_0..D_9.
- Consecutive failed loads are counted; once the limit is reached the key is permanently zeroed.
- Sits between the test/config port and the obfuscated combinational core.

---
 rtl/key_ctrl_pkg.sv | 24 ++
 rtl/key_shift_par.sv | 47 ++++
 rtl/key_load_ctrl.sv | 136 +++++++++++++
 tb/tb_key_load_ctrl.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/key_ctrl_pkg.sv
// Shared types and constants for the serial key-load controller of the obfuscated c17 core.
package key_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_CHECK,
    ST_COMMIT,
    ST_ERROR,
    ST_LOCKED,
    ST_DEAD
  } state_e;

  localparam int unsigned KEY_W_DEF = 10;
  // Each obfuscation mux takes two adjacent key bits: key[2n+1:2n] = {D_(2n+1), D_(2n)}.
  localparam int unsigned SEL_BITS  = 2;
  localparam int unsigned NUM_MUX   = KEY_W_DEF / SEL_BITS;

  function automatic logic [SEL_BITS-1:0] mux_sel(input logic [KEY_W_DEF-1:0] key,
                                                  input int unsigned           n);
    return key[SEL_BITS*n +: SEL_BITS];
  endfunction

endpackage

// File: rtl/key_shift_par.sv
// Shadow shift register with running parity and bit counter; the final bit is parity only.
module key_shift_par
  import key_ctrl_pkg::*;
#(
  parameter int unsigned KEY_W = KEY_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             shift_en,
  input  logic             bit_in,
  output logic [KEY_W-1:0] shadow,
  output logic             p,
  output logic             last_bit
);

  localparam int unsigned CNT_W = $clog2(KEY_W + 2);

  logic [KEY_W-1:0] r_shadow;
  logic             r_p;
  logic [CNT_W-1:0] r_bit_cnt;
  logic             w_last;

  assign w_last = (r_bit_cnt == CNT_W'(KEY_W));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_shadow  <= '0;
      r_p       <= 1'b0;
      r_bit_cnt <= '0;
    end else if (clr) begin
      r_shadow  <= '0;
      r_p       <= 1'b0;
      r_bit_cnt <= '0;
    end else if (shift_en) begin
      // LSB-first stream: entering at the MSB leaves the first bit at bit 0.
      if (!w_last) r_shadow <= {bit_in, r_shadow[KEY_W-1:1]};
      r_p       <= r_p ^ bit_in;
      r_bit_cnt <= r_bit_cnt + CNT_W'(1);
    end
  end

  assign shadow   = r_shadow;
  assign p        = r_p;
  assign last_bit = w_last;

endmodule

// File: rtl/key_load_ctrl.sv
// Key-load FSM: framed serial load, parity check, atomic commit, fail counting and kill state.
module key_load_ctrl
  import key_ctrl_pkg::*;
#(
  parameter int unsigned KEY_W     = KEY_W_DEF,
  parameter int unsigned MAX_FAIL  = 3,
  parameter bit          LOCK_ONCE = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic             key_valid,
  input  logic             key_bit,
  output logic             key_ready,
  input  logic             clr_err,
  output logic [KEY_W-1:0] key_out,
  output logic             key_active,
  output logic             busy,
  output logic             error,
  output logic             locked,
  output logic             dead
);

  state_e           r_state;
  state_e           w_state_nxt;
  logic [KEY_W-1:0] r_key_out;
  logic             r_key_active;
  logic [3:0]       r_fail_cnt;
  logic [3:0]       w_fail_inc;

  logic             w_shift_en;
  logic             w_clr;
  logic             w_commit;
  logic             w_fail;
  logic             w_kill;
  logic [KEY_W-1:0] w_shadow;
  logic             w_p;
  logic             w_last_bit;

  key_shift_par #(
    .KEY_W (KEY_W)
  ) u_shift (
    .clk      (clk),
    .rst      (rst),
    .clr      (w_clr),
    .shift_en (w_shift_en),
    .bit_in   (key_bit),
    .shadow   (w_shadow),
    .p        (w_p),
    .last_bit (w_last_bit)
  );

  assign w_fail_inc = r_fail_cnt + 4'd1;

  always_comb begin
    w_state_nxt = r_state;
    w_shift_en  = 1'b0;
    w_clr       = 1'b0;
    w_commit    = 1'b0;
    w_fail      = 1'b0;
    w_kill      = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_clr       = 1'b1;
          w_state_nxt = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        // Abort beats a simultaneously offered bit.
        if (abort) begin
          w_state_nxt = ST_IDLE;
        end else if (key_valid) begin
          w_shift_en = 1'b1;
          if (w_last_bit) w_state_nxt = ST_CHECK;
        end
      end
      ST_CHECK: begin
        if (abort) begin
          w_state_nxt = ST_IDLE;
        end else if (!w_p) begin
          w_state_nxt = ST_COMMIT;
        end else begin
          w_fail = 1'b1;
          if (w_fail_inc == 4'(MAX_FAIL)) begin
            w_kill      = 1'b1;
            w_state_nxt = ST_DEAD;
          end else begin
            w_state_nxt = ST_ERROR;
          end
        end
      end
      ST_COMMIT: begin
        w_commit    = 1'b1;
        w_state_nxt = LOCK_ONCE ? ST_LOCKED : ST_IDLE;
      end
      ST_ERROR: begin
        if (clr_err) w_state_nxt = ST_IDLE;
      end
      ST_LOCKED: w_state_nxt = ST_LOCKED;
      ST_DEAD:   w_state_nxt = ST_DEAD;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_key_out    <= '0;
      r_key_active <= 1'b0;
      r_fail_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_commit) begin
        r_key_out    <= w_shadow;
        r_key_active <= 1'b1;
        r_fail_cnt   <= '0;
      end
      if (w_fail) r_fail_cnt <= w_fail_inc;
      if (w_kill) begin
        r_key_out    <= '0;
        r_key_active <= 1'b0;
      end
    end
  end

  assign key_ready  = (r_state == ST_SHIFT);
  assign busy       = (r_state == ST_SHIFT) || (r_state == ST_CHECK) || (r_state == ST_COMMIT);
  assign error      = (r_state == ST_ERROR);
  assign locked     = (r_state == ST_LOCKED) || (r_state == ST_DEAD);
  assign dead       = (r_state == ST_DEAD);
  assign key_out    = r_key_out;
  assign key_active = r_key_active;

endmodule

// File: tb/tb_key_load_ctrl.sv
// Directed bench: one locking and one reprogrammable instance share the same stimulus.
module tb_key_load_ctrl;

  localparam int unsigned KW = 10;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0;
  logic abort = 1'b0;
  logic key_valid = 1'b0;
  logic key_bit = 1'b0;
  logic clr_err = 1'b0;

  logic [KW-1:0] lk_key_out, rp_key_out;
  logic lk_ready, lk_active, lk_busy, lk_error, lk_locked, lk_dead;
  logic rp_ready, rp_active, rp_busy, rp_error, rp_locked, rp_dead;

  key_load_ctrl #(.KEY_W(KW), .MAX_FAIL(3), .LOCK_ONCE(1'b1)) u_dut_lock (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .key_valid(key_valid),
    .key_bit(key_bit), .key_ready(lk_ready), .clr_err(clr_err), .key_out(lk_key_out),
    .key_active(lk_active), .busy(lk_busy), .error(lk_error), .locked(lk_locked),
    .dead(lk_dead)
  );

  key_load_ctrl #(.KEY_W(KW), .MAX_FAIL(3), .LOCK_ONCE(1'b0)) u_dut_reprog (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .key_valid(key_valid),
    .key_bit(key_bit), .key_ready(rp_ready), .clr_err(clr_err), .key_out(rp_key_out),
    .key_active(rp_active), .busy(rp_busy), .error(rp_error), .locked(rp_locked),
    .dead(rp_dead)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  logic watch = 1'b0;

  typedef struct {
    logic [KW-1:0] key;
    logic          par;
    logic          ok;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  // Ends one cycle after the parity-bit edge, i.e. with the DUT in CHECK.
  task automatic send_word(input logic [KW-1:0] k, input logic par);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < int'(KW); i++) begin
      key_valid = 1'b1;
      key_bit   = k[i];
      tick();
    end
    key_bit = par;
    tick();
    key_valid = 1'b0;
    key_bit   = 1'b0;
  endtask

  task automatic bad_load();
    send_word(10'h2B5, 1'b1);
    tick();
  endtask

  task automatic pulse_clr();
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
  endtask

  // Atomic update: during a reload only the old or the new key may ever be visible.
  always @(negedge clk) begin
    if (watch) begin
      n_checks++;
      if (rp_key_out !== 10'h155 && rp_key_out !== 10'h0AA) begin
        n_fail++;
        $display("FAIL atomic_key_out: got 0x%0h, expected 0x155 or 0x0aa", rp_key_out);
      end
    end
  end

  initial begin
    vecs[0] = '{key: 10'h2B5, par: 1'b0, ok: 1'b1};
    vecs[1] = '{key: 10'h2B5, par: 1'b1, ok: 1'b0};
    vecs[2] = '{key: 10'h000, par: 1'b0, ok: 1'b1};
    vecs[3] = '{key: 10'h3FF, par: 1'b0, ok: 1'b1};
    vecs[4] = '{key: 10'h001, par: 1'b1, ok: 1'b1};
    vecs[5] = '{key: 10'h001, par: 1'b0, ok: 1'b0};
    vecs[6] = '{key: 10'h200, par: 1'b0, ok: 1'b0};

    #1 rst = 1'b1;
    #1;
    check("rst_key_out", 32'(lk_key_out), 32'h0);
    check("rst_key_active", 32'(lk_active), 32'h0);
    check("rst_status", {26'h0, lk_busy, lk_error, lk_locked, lk_dead, lk_ready, rp_busy}, 32'h0);
    tick();
    rst = 1'b0;

    // Async reset in the middle of SHIFT clears a previously committed key at once.
    send_word(10'h155, 1'b1);
    tick();
    tick();
    check("pre_reset_key", 32'(rp_key_out), 32'h155);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      key_valid = 1'b1;
      key_bit   = 1'b1;
      tick();
    end
    key_valid = 1'b0;
    check("mid_shift_ready", 32'(rp_ready), 32'h1);
    rst = 1'b1;
    #1;
    check("async_rst_key", 32'(rp_key_out), 32'h0);
    check("async_rst_busy", 32'(rp_busy), 32'h0);
    check("async_rst_ready", 32'(rp_ready), 32'h0);
    tick();
    rst = 1'b0;
    send_word(10'h2B5, 1'b0);
    tick();
    check("commit_latency_old", 32'(lk_key_out), 32'h0);
    tick();
    check("commit_latency_new", 32'(lk_key_out), 32'h2B5);
    check("commit_locked", 32'(lk_locked), 32'h1);

    // Single loads from a clean reset, against the locking instance.
    for (int v = 0; v < 7; v++) begin
      do_reset();
      send_word(vecs[v].key, vecs[v].par);
      check($sformatf("v%0d_busy_check", v), 32'(lk_busy), 32'h1);
      tick();
      tick();
      check($sformatf("v%0d_key_out", v), 32'(lk_key_out),
            vecs[v].ok ? 32'(vecs[v].key) : 32'h0);
      check($sformatf("v%0d_active", v), 32'(lk_active), 32'(vecs[v].ok));
      check($sformatf("v%0d_locked", v), 32'(lk_locked), 32'(vecs[v].ok));
      check($sformatf("v%0d_error", v), 32'(lk_error), 32'(!vecs[v].ok));
      start = 1'b1;
      tick();
      start = 1'b0;
      check($sformatf("v%0d_start_ignored", v), 32'(lk_busy), 32'h0);
    end

    // Error, clr_err with simultaneous start, reload; then fail count must restart from zero.
    do_reset();
    bad_load();
    check("err_flag", 32'(lk_error), 32'h1);
    check("err_key_kept", 32'(lk_key_out), 32'h0);
    clr_err = 1'b1;
    start   = 1'b1;
    tick();
    clr_err = 1'b0;
    start   = 1'b0;
    check("clr_err_cleared", 32'(lk_error), 32'h0);
    check("clr_start_ignored", 32'(lk_busy), 32'h0);
    tick();
    check("clr_still_idle", 32'(lk_busy), 32'h0);
    send_word(10'h2B5, 1'b0);
    tick();
    tick();
    check("reload_key", 32'(lk_key_out), 32'h2B5);
    check("reload_locked", 32'(lk_locked), 32'h1);
    check("reload_rp_key", 32'(rp_key_out), 32'h2B5);
    bad_load();
    pulse_clr();
    bad_load();
    pulse_clr();
    check("fail_cnt_reset_not_dead", 32'(rp_dead), 32'h0);
    bad_load();
    check("fail_cnt_third_dead", 32'(rp_dead), 32'h1);

    // Three consecutive failures kill a previously committed key.
    do_reset();
    send_word(10'h155, 1'b1);
    tick();
    tick();
    check("dead_pre_key", 32'(rp_key_out), 32'h155);
    bad_load();
    check("fail1_error", {30'h0, rp_error, rp_dead}, 32'h2);
    check("fail1_key_kept", 32'(rp_key_out), 32'h155);
    pulse_clr();
    bad_load();
    check("fail2_error", {30'h0, rp_error, rp_dead}, 32'h2);
    pulse_clr();
    bad_load();
    check("fail3_dead", {29'h0, rp_error, rp_dead, rp_locked}, 32'h3);
    check("fail3_key_zero", 32'(rp_key_out), 32'h0);
    check("fail3_inactive", 32'(rp_active), 32'h0);
    send_word(10'h155, 1'b1);
    check("dead_start_ignored", {30'h0, rp_busy, rp_dead}, 32'h1);

    // Reprogramming with no intermediate key value visible.
    do_reset();
    send_word(10'h155, 1'b1);
    tick();
    tick();
    check("reprog_first", 32'(rp_key_out), 32'h155);
    check("reprog_idle", {30'h0, rp_busy, rp_locked}, 32'h0);
    watch = 1'b1;
    send_word(10'h0AA, 1'b0);
    check("reprog_in_check", 32'(rp_key_out), 32'h155);
    tick();
    check("reprog_in_commit", 32'(rp_key_out), 32'h155);
    tick();
    check("reprog_second", 32'(rp_key_out), 32'h0AA);
    check("reprog_active", 32'(rp_active), 32'h1);
    tick();
    watch = 1'b0;

    // Long stall, then abort together with a valid bit; then abort while in CHECK.
    do_reset();
    send_word(10'h155, 1'b1);
    tick();
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      key_valid = 1'b1;
      key_bit   = 1'b0;
      tick();
    end
    key_valid = 1'b0;
    repeat (20) tick();
    check("stall_still_shift", {30'h0, rp_busy, rp_ready}, 32'h3);
    abort     = 1'b1;
    key_valid = 1'b1;
    key_bit   = 1'b1;
    tick();
    abort     = 1'b0;
    key_valid = 1'b0;
    key_bit   = 1'b0;
    check("abort_idle", {30'h0, rp_busy, rp_ready}, 32'h0);
    check("abort_key_kept", 32'(rp_key_out), 32'h155);
    send_word(10'h0AA, 1'b0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    tick();
    check("abort_check_idle", 32'(rp_busy), 32'h0);
    check("abort_check_no_commit", 32'(rp_key_out), 32'h155);
    send_word(10'h0AA, 1'b0);
    tick();
    tick();
    check("after_abort_reload", 32'(rp_key_out), 32'h0AA);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
